// File: rtl/dxball_pkg.sv
// Shared definitions for the rectangle plotter: object codes, colours,
// screen geometry, plotter state encoding and a rectangle hit test.
package dxball_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [1:0] OBJ_BALL   = 2'b00;
    localparam logic [1:0] OBJ_PADDLE = 2'b01;
    localparam logic [1:0] OBJ_BLOCK  = 2'b10;
    localparam logic [1:0] OBJ_NONE   = 2'b11;

    localparam logic [2:0] COL_BG     = 3'b000;
    localparam logic [2:0] COL_BALL   = 3'b111;
    localparam logic [2:0] COL_PADDLE = 3'b010;
    localparam logic [2:0] COL_BLOCK  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ERASE,
        ST_DRAW,
        ST_FIN
    } plot_state_t;

    // True when (col,row) lies inside the rectangle at (ox,oy) of size sx x sy.
    // End coordinates are formed one bit wider so they never wrap.
    function automatic logic in_rect(input logic [8:0] col, input logic [7:0] row,
                                     input logic [7:0] ox,  input logic [6:0] oy,
                                     input logic [7:0] sx,  input logic [6:0] sy);
        logic [8:0] ex;
        logic [7:0] ey;
        ex = {1'b0, ox} + {1'b0, sx};
        ey = {1'b0, oy} + {1'b0, sy};
        return (col >= {1'b0, ox}) && (col < ex) && (row >= {1'b0, oy}) && (row < ey);
    endfunction

endpackage

// File: rtl/rect_scanner.sv
// Row-major raster walker over a rectangle. Holds the offset of the pixel
// currently on the plotter outputs and exposes the coordinates of the next
// one, so the plotter can register each pixel one cycle ahead.
module rect_scanner (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       advance,
    input  logic [7:0] org_x,
    input  logic [6:0] org_y,
    input  logic [7:0] size_x,
    input  logic [6:0] size_y,
    output logic [8:0] next_col,
    output logic [7:0] next_row,
    output logic       last,
    output logic       empty
);

    logic [7:0] ox_q;
    logic [6:0] oy_q;
    logic [7:0] sx_q;
    logic [6:0] sy_q;
    logic [7:0] cx;
    logic [6:0] cy;
    logic       wrap;
    logic [7:0] nxt_cx;
    logic [6:0] nxt_cy;

    // Emptiness is judged on the size being presented for loading.
    assign empty    = (size_x == 8'd0) || (size_y == 7'd0);
    assign wrap     = (cx == sx_q - 8'd1);
    assign last     = wrap && (cy == sy_q - 7'd1);
    assign nxt_cx   = wrap ? 8'd0 : cx + 8'd1;
    assign nxt_cy   = wrap ? cy + 7'd1 : cy;
    assign next_col = {1'b0, ox_q} + {1'b0, nxt_cx};
    assign next_row = {1'b0, oy_q} + {1'b0, nxt_cy};

    // Capture origin and size of the rectangle being walked.
    always_ff @(posedge clk) begin
        if (load) begin
            ox_q <= org_x;
            oy_q <= org_y;
            sx_q <= size_x;
            sy_q <= size_y;
        end
    end

    // Column counter is the inner loop, row counter the outer loop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cx <= 8'd0;
            cy <= 7'd0;
        end else if (load) begin
            cx <= 8'd0;
            cy <= 7'd0;
        end else if (advance) begin
            cx <= nxt_cx;
            cy <= nxt_cy;
        end
    end

endmodule

// File: rtl/rect_plotter.sv
// Erase-then-draw rectangle plotter feeding a 160x120 VGA frame buffer,
// one pixel per clock. Optional macro RECT_PLOTTER_NOFLICKER_EN suppresses
// erase writes to pixels that the draw phase will repaint.
module rect_plotter
    import dxball_pkg::*;
#(
    parameter int         MAX_X         = SCREEN_W - 1,
    parameter int         MAX_Y         = SCREEN_H - 1,
    parameter logic [2:0] BG_COLOUR     = COL_BG,
    parameter logic [2:0] BALL_COLOUR   = COL_BALL,
    parameter logic [2:0] PADDLE_COLOUR = COL_PADDLE,
    parameter logic [2:0] BLOCK_COLOUR  = COL_BLOCK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_plot,
    input  logic [1:0] object,
    input  logic [7:0] new_x,
    input  logic [6:0] new_y,
    input  logic [7:0] old_x,
    input  logic [6:0] old_y,
    input  logic [7:0] size_x,
    input  logic [6:0] size_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    plot_state_t state;

    logic [1:0] obj_q;
    logic [7:0] nx_q;
    logic [6:0] ny_q;
    logic [7:0] sx_q;
    logic [6:0] sy_q;

    logic       accept;
    logic [7:0] ld_x;
    logic [6:0] ld_y;
    logic [7:0] ld_sx;
    logic [6:0] ld_sy;
    logic       scan_load;
    logic       scan_adv;
    logic       scan_last;
    logic       scan_empty;
    logic [8:0] next_col;
    logic [7:0] next_row;
    logic       hide_first;
    logic       hide_next;

    function automatic logic on_screen(input logic [8:0] col, input logic [7:0] row);
        return (col <= 9'(MAX_X)) && (row <= 8'(MAX_Y));
    endfunction

    function automatic logic [2:0] obj_colour(input logic [1:0] obj);
        case (obj)
            OBJ_BALL:   return BALL_COLOUR;
            OBJ_PADDLE: return PADDLE_COLOUR;
            OBJ_BLOCK:  return BLOCK_COLOUR;
            default:    return BG_COLOUR;
        endcase
    endfunction

    assign accept = (state == ST_IDLE) && start_plot;

    // The scanner is loaded from the live ports on acceptance and from the
    // latched new rectangle when switching from erase to draw.
    always_comb begin
        ld_x  = nx_q;
        ld_y  = ny_q;
        ld_sx = sx_q;
        ld_sy = sy_q;
        if (state == ST_IDLE) begin
            ld_x  = old_x;
            ld_y  = old_y;
            ld_sx = size_x;
            ld_sy = size_y;
        end
    end

    assign scan_load = accept || ((state == ST_ERASE) && scan_last && (obj_q != OBJ_NONE));
    assign scan_adv  = ((state == ST_ERASE) || (state == ST_DRAW)) && !scan_last;

`ifdef RECT_PLOTTER_NOFLICKER_EN
    assign hide_first = in_rect({1'b0, old_x}, {1'b0, old_y}, new_x, new_y, size_x, size_y);
    assign hide_next  = (state == ST_ERASE) && in_rect(next_col, next_row, nx_q, ny_q, sx_q, sy_q);
`else
    assign hide_first = 1'b0;
    assign hide_next  = 1'b0;
`endif

    rect_scanner u_scanner (
        .clk      (clk),
        .reset    (reset),
        .load     (scan_load),
        .advance  (scan_adv),
        .org_x    (ld_x),
        .org_y    (ld_y),
        .size_x   (ld_sx),
        .size_y   (ld_sy),
        .next_col (next_col),
        .next_row (next_row),
        .last     (scan_last),
        .empty    (scan_empty)
    );

    // Latch the request so the ports may change once it is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            obj_q <= object;
            nx_q  <= new_x;
            ny_q  <= new_y;
            sx_q  <= size_x;
            sy_q  <= size_y;
        end
    end

    // Sequencer: each transition registers the pixel shown in the next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            x      <= 8'd0;
            y      <= 7'd0;
            colour <= 3'd0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_plot) begin
                        busy <= 1'b1;
                        if (scan_empty) begin
                            state <= ST_FIN;
                            plot  <= 1'b0;
                        end else begin
                            state  <= ST_ERASE;
                            x      <= old_x;
                            y      <= old_y;
                            colour <= BG_COLOUR;
                            plot   <= on_screen({1'b0, old_x}, {1'b0, old_y}) && !hide_first;
                        end
                    end
                end
                ST_ERASE: begin
                    if (!scan_last) begin
                        x      <= next_col[7:0];
                        y      <= next_row[6:0];
                        colour <= BG_COLOUR;
                        plot   <= on_screen(next_col, next_row) && !hide_next;
                    end else if (obj_q == OBJ_NONE) begin
                        state <= ST_FIN;
                        plot  <= 1'b0;
                    end else begin
                        state  <= ST_DRAW;
                        x      <= nx_q;
                        y      <= ny_q;
                        colour <= obj_colour(obj_q);
                        plot   <= on_screen({1'b0, nx_q}, {1'b0, ny_q});
                    end
                end
                ST_DRAW: begin
                    if (!scan_last) begin
                        x      <= next_col[7:0];
                        y      <= next_row[6:0];
                        colour <= obj_colour(obj_q);
                        plot   <= on_screen(next_col, next_row);
                    end else begin
                        state <= ST_FIN;
                        plot  <= 1'b0;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    plot  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rect_plotter.sv
// Self-checking bench for rect_plotter: a scoreboard of expected plotted
// pixels is filled per request and drained by a pixel monitor; each test
// task checks busy length, done timing and scoreboard drain inline.
module tb_rect_plotter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_plot = 1'b0;
    logic [1:0] object = 2'b00;
    logic [7:0] new_x = 8'd0;
    logic [6:0] new_y = 7'd0;
    logic [7:0] old_x = 8'd0;
    logic [6:0] old_y = 7'd0;
    logic [7:0] size_x = 8'd0;
    logic [6:0] size_y = 7'd0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [17:0] sb[$];

    rect_plotter dut (
        .clk        (clk),
        .reset      (reset),
        .start_plot (start_plot),
        .object     (object),
        .new_x      (new_x),
        .new_y      (new_y),
        .old_x      (old_x),
        .old_y      (old_y),
        .size_x     (size_x),
        .size_y     (size_y),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Pixel monitor: every plotted pixel must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && plot) begin
            logic [17:0] exp_pix;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pixel_unexpected: got x=%0d y=%0d colour=%0d, required no plot", x, y, colour);
            end else begin
                exp_pix = sb.pop_front();
                if ({x, y, colour} !== exp_pix) begin
                    errors++;
                    $display("FAIL pixel: got x=%0d y=%0d colour=%0d, required x=%0d y=%0d colour=%0d",
                             x, y, colour, exp_pix[17:10], exp_pix[9:3], exp_pix[2:0]);
                end
            end
        end
    end

    function automatic logic [2:0] draw_colour(input logic [1:0] obj);
        case (obj)
            2'b00:   return 3'b111;
            2'b01:   return 3'b010;
            2'b10:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Reference model: push every pixel that should be written, in order.
    task automatic model(input logic [1:0] obj, input int ox, input int oy, input int nx,
                         input int ny, input int sx, input int sy);
        for (int r = 0; r < sy; r++) begin
            for (int c = 0; c < sx; c++) begin
                int  col = ox + c;
                int  row = oy + r;
                bit  hide = 0;
`ifdef RECT_PLOTTER_NOFLICKER_EN
                hide = (col >= nx) && (col < nx + sx) && (row >= ny) && (row < ny + sy);
`endif
                if (col < 160 && row < 120 && !hide)
                    sb.push_back({8'(col), 7'(row), 3'b000});
            end
        end
        if (obj != 2'b11) begin
            for (int r = 0; r < sy; r++) begin
                for (int c = 0; c < sx; c++) begin
                    int col = nx + c;
                    int row = ny + r;
                    if (col < 160 && row < 120)
                        sb.push_back({8'(col), 7'(row), draw_colour(obj)});
                end
            end
        end
    endtask

    // Present a request, let it be accepted, then scramble the ports.
    task automatic issue(input logic [1:0] obj, input int ox, input int oy, input int nx,
                         input int ny, input int sx, input int sy, input bit hold);
        @(negedge clk);
        object = obj;
        old_x  = 8'(ox);
        old_y  = 7'(oy);
        new_x  = 8'(nx);
        new_y  = 7'(ny);
        size_x = 8'(sx);
        size_y = 7'(sy);
        start_plot = 1'b1;
        model(obj, ox, oy, nx, ny, sx, sy);
        @(posedge clk);
        #1;
        if (!hold) begin
            start_plot = 1'b0;
            object = 2'($urandom);
            old_x  = 8'($urandom);
            old_y  = 7'($urandom);
            new_x  = 8'($urandom);
            new_y  = 7'($urandom);
            size_x = 8'($urandom);
            size_y = 7'($urandom);
        end
    endtask

    // Observe a bounded window after acceptance; optionally pulse start_plot once.
    task automatic run_window(input int budget, input int inject_cyc, output int busy_cnt,
                              output int done_cyc, output int done_cnt);
        busy_cnt = 0;
        done_cyc = -1;
        done_cnt = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            start_plot = (c == inject_cyc);
        end
        start_plot = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks += 6;
        if (x !== 8'd0)      begin errors++; $display("FAIL reset_x: got %0d, required 0", x); end
        if (y !== 7'd0)      begin errors++; $display("FAIL reset_y: got %0d, required 0", y); end
        if (colour !== 3'd0) begin errors++; $display("FAIL reset_colour: got %0d, required 0", colour); end
        if (plot !== 1'b0)   begin errors++; $display("FAIL reset_plot: got %0b, required 0", plot); end
        if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %0b, required 0", busy); end
        if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %0b, required 0", done); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_ball(input int inject);
        int bc, dc, dn;
        issue(2'b00, 10, 20, 11, 21, 4, 4, 0);
        run_window(40, inject, bc, dc, dn);
        checks += 4;
        if (bc !== 33) begin errors++; $display("FAIL ball_busy (inject %0d): got %0d cycles, required 33", inject, bc); end
        if (dc !== 34) begin errors++; $display("FAIL ball_done_cycle (inject %0d): got %0d, required 34", inject, dc); end
        if (dn !== 1)  begin errors++; $display("FAIL ball_done_count (inject %0d): got %0d, required 1", inject, dn); end
        if (sb.size() !== 0) begin errors++; $display("FAIL ball_missing_pixels: got %0d left, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_paddle();
        int bc, dc, dn;
        issue(2'b01, 100, 117, 99, 117, 20, 1, 0);
        run_window(46, 0, bc, dc, dn);
        checks += 3;
        if (bc !== 41 || dn !== 1) begin errors++; $display("FAIL paddle_busy: got %0d cycles %0d dones, required 41 cycles 1 done", bc, dn); end
        if (dc !== 42) begin errors++; $display("FAIL paddle_done_cycle: got %0d, required 42", dc); end
        if (sb.size() !== 0) begin errors++; $display("FAIL paddle_missing_pixels: got %0d left, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_clip();
        int bc, dc, dn;
        issue(2'b10, 150, 110, 157, 118, 4, 4, 0);
        run_window(40, 0, bc, dc, dn);
        checks += 3;
        if (bc !== 33) begin errors++; $display("FAIL clip_busy: got %0d, required 33", bc); end
        if (dc !== 34 || dn !== 1) begin errors++; $display("FAIL clip_done: got cycle %0d count %0d, required cycle 34 count 1", dc, dn); end
        if (sb.size() !== 0) begin errors++; $display("FAIL clip_missing_pixels: got %0d left, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_zero_none();
        int bc, dc, dn;
        issue(2'b00, 30, 30, 31, 31, 0, 3, 0);
        run_window(6, 0, bc, dc, dn);
        checks += 2;
        if (bc !== 1) begin errors++; $display("FAIL zero_busy: got %0d, required 1", bc); end
        if (dc !== 2 || dn !== 1) begin errors++; $display("FAIL zero_done: got cycle %0d count %0d, required cycle 2 count 1", dc, dn); end
        issue(2'b11, 5, 5, 6, 6, 2, 2, 0);
        run_window(10, 0, bc, dc, dn);
        checks += 3;
        if (bc !== 5) begin errors++; $display("FAIL none_busy: got %0d, required 5", bc); end
        if (dc !== 6 || dn !== 1) begin errors++; $display("FAIL none_done: got cycle %0d count %0d, required cycle 6 count 1", dc, dn); end
        if (sb.size() !== 0) begin errors++; $display("FAIL none_missing_pixels: got %0d left, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_back_to_back();
        int bc = 0;
        int d1 = -1;
        int d2 = -1;
        int dn = 0;
        issue(2'b00, 40, 50, 41, 50, 4, 4, 1);
        model(2'b00, 40, 50, 41, 50, 4, 4);
        for (int c = 1; c <= 75; c++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                dn++;
                if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
            end
            if (c == 35) start_plot = 1'b0;
        end
        checks += 3;
        if (bc !== 66) begin errors++; $display("FAIL b2b_busy: got %0d, required 66", bc); end
        if (d1 !== 34 || d2 !== 68 || dn !== 2) begin
            errors++;
            $display("FAIL b2b_done: got %0d/%0d count %0d, required 34/68 count 2", d1, d2, dn);
        end
        if (sb.size() !== 0) begin errors++; $display("FAIL b2b_missing_pixels: got %0d left, required 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_reset_abort();
        int dn = 0;
        issue(2'b00, 60, 60, 61, 61, 4, 4, 0);
        // Draw pixel 5 is on the outputs during cycle 21.
        repeat (21) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks += 3;
        if (plot !== 1'b0) begin errors++; $display("FAIL abort_plot: got %0b, required 0", plot); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b, required 0", busy); end
        if (x !== 8'd0)    begin errors++; $display("FAIL abort_x: got %0d, required 0", x); end
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            if (done) dn++;
        end
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done || plot) dn++;
        end
        checks++;
        if (dn !== 0) begin errors++; $display("FAIL abort_quiet: got %0d done/plot cycles, required 0", dn); end
        test_ball(0);
    endtask

    initial begin
        test_reset();
        test_ball(0);
        test_paddle();
        test_clip();
        test_ball(5);
        test_zero_none();
        test_back_to_back();
        test_reset_abort();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
